// File: rtl/serializador_pkg.sv
// Shared types and constants for the serial register-word transmitter.
// State encoding, line idle level and default frame geometry.
package serializador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   WIDTH_DEF  = 5;
  localparam int   DIV_DEF    = 4;

endpackage

// File: rtl/serializador_registro_tick.sv
// Bit-period counter: one-cycle tick every DIV cycles while enabled.
// Ports: clk, reset (async, active-low), en, clr -> tick.
module generador_tick
  import serializador_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serializador_registro.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Ports: clk, reset (async, active-low), start, din -> tx, busy, done.
module serializador_registro
  import serializador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV   = DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;
  logic             tick_clr;
  logic             tick_en;

  assign tick_en = (state_q != IDLE);

  generador_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tick_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
        if (start) begin
          shreg_d  = din;
          idx_d    = '0;
          tick_clr = 1'b1;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (tick) begin
          idx_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          // next bit is taken from the shifted value so WIDTH=1 works
          shreg_d = shreg_q >> 1;
          if (idx_q == IW'(WIDTH - 1)) begin
            idx_d   = IW'(WIDTH);
            tx_d    = IDLE_LEVEL;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
            tx_d  = shreg_d[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          tx_d    = IDLE_LEVEL;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serializador_registro.sv
// Bench for serializador_registro: frame-level reference model,
// per-cycle compare, plus literal frame checks.
module tb_serializador_registro;

  localparam int W     = 5;
  localparam int D     = 4;
  localparam int FRAME = D * (W + 2);

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] din   = '0;
  logic         tx;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serializador_registro #(
    .WIDTH (W),
    .DIV   (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (din),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Model: m_j = edges elapsed since the accepting edge.
  bit           m_act  = 1'b0;
  bit           m_done = 1'b0;
  int           m_j    = 0;
  logic [W-1:0] m_word = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act  = 1'b0;
      m_done = 1'b0;
      m_j    = 0;
    end else begin
      m_done = 1'b0;
      if (m_act) begin
        m_j++;
        if (m_j == FRAME) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end else if (start === 1'b1) begin
        m_act  = 1'b1;
        m_j    = 0;
        m_word = din;
      end
    end
  end

  function automatic logic exp_tx();
    int slot;
    if (!m_act) return 1'b1;
    slot = m_j / D;
    if (slot == 0) return 1'b0;
    if (slot <= W) return m_word[slot-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    chk("tx", tx, exp_tx());
    chk("busy", busy, m_act);
    chk("done", done, m_done);
  end

  // One frame with literal per-slot levels; optional start poke at k+10.
  task automatic lit_frame(input logic [W-1:0] w, input logic [0:6] sl,
                           input bit poke);
    int dn;
    dn = 0;
    @(negedge clk);
    start = 1'b1;
    din   = w;
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = W'($urandom);
    for (int j = 0; j <= FRAME; j++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (j % D == 1) chk("lit_tx", tx, sl[j/D]);
      if (j < FRAME) chk("lit_busy", busy, 1'b1);
      if (j == FRAME) begin
        chk("lit_done", done, 1'b1);
        chk("lit_idle", busy, 1'b0);
      end
      if (poke && j == 9) begin
        start = 1'b1;
        din   = 5'b11111;
      end
      if (poke && j == 10) start = 1'b0;
    end
    chk("done_count", dn, 1);
  endtask

  initial begin
    logic [0:13] bb;
    int dn;
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:13] bb;
    int dn;
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom);
      din   = W'($urandom);
    end
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b0);

    lit_frame(5'b10110, 7'b0011011, 1'b0);
    lit_frame(5'b10110, 7'b0011011, 1'b1);
    repeat (FRAME + 4) @(negedge clk);
    chk("no_second", busy, 1'b0);

    // back-to-back with start held high
    bb = 14'b0100001_0011111;
    dn = 0;
    @(negedge clk);
    start = 1'b1;
    din   = 5'b00001;
    @(posedge clk);
    #1;
    din = 5'b11110;
    for (int j = 0; j <= FRAME + 1 + FRAME; j++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (j < FRAME && j % D == 1) chk("bb_tx", tx, bb[j/D]);
      if (j > FRAME && (j - FRAME - 1) % D == 1)
        chk("bb_tx", tx, bb[7 + (j - FRAME - 1) / D]);
      if (j == FRAME) chk("bb_gap", tx, 1'b1);
      if (j == FRAME + 1) begin
        chk("bb_restart", tx, 1'b0);
        start = 1'b0;
      end
    end
    chk("bb_dones", dn, 2);

    // reset during data bit 2
    repeat (3) @(negedge clk);
    start = 1'b1;
    din   = W'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      start = 1'($urandom);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    repeat (D * 3) @(negedge clk);
    chk("no_resume", busy, 1'b0);
    lit_frame(5'b01010, 7'b0010101, 1'b0);

    lit_frame(5'b00000, 7'b0000001, 1'b0);
    lit_frame(5'b11111, 7'b0111111, 1'b0);

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 4) == 0);
      din   = W'($urandom);
      reset = ($urandom_range(0, 120) != 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    repeat (FRAME + 4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
